sp_ctrl: RTL

SP_CTRL -- requirements
Module: sp_ctrl

---
 rtl/sp_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sp_ctrl.sv
// Stack-pointer burst controller: sequences push/pop bursts against an external
// SP register, checks stack bounds per word, and raises sticky overflow/underflow flags.
module sp_ctrl #(
   parameter int unsigned         SP_WIDTH    = 32,
   parameter int unsigned         WORD_BYTES  = 4,
   parameter logic [SP_WIDTH-1:0] STACK_TOP   = 32'h0000_1000,
   parameter logic [SP_WIDTH-1:0] STACK_LIMIT = 32'h0000_0F00
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_op,
   input  logic [3:0]          req_count,
   input  logic                sp_wr_valid,
   output logic                sp_wr_ready,
   input  logic [SP_WIDTH-1:0] sp_wr_data,
   input  logic [SP_WIDTH-1:0] sp_q,
   output logic [SP_WIDTH-1:0] sp_d,
   output logic                sp_en,
   output logic [SP_WIDTH-1:0] mem_addr,
   output logic                mem_we,
   output logic                mem_re,
   output logic [3:0]          word_idx,
   output logic                done,
   output logic                err_ovf,
   output logic                err_unf,
   input  logic                err_clr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Bounds are compared one bit wider than the SP so neither side can wrap.
   localparam logic [SP_WIDTH:0]   STEP_EXT = (SP_WIDTH+1)'(WORD_BYTES);
   localparam logic [SP_WIDTH:0]   PUSH_MIN = {1'b0, STACK_LIMIT} + STEP_EXT;
   localparam logic [SP_WIDTH:0]   POP_MAX  = {1'b0, STACK_TOP};
   localparam logic [SP_WIDTH-1:0] STEP     = SP_WIDTH'(WORD_BYTES);

   state_t     state;
   state_t     state_next;
   logic [3:0] remain;
   logic [3:0] remain_next;
   logic [3:0] idx;
   logic [3:0] idx_next;
   logic       ovf_flag;
   logic       unf_flag;
   logic       ovf_set;
   logic       unf_set;
   logic       push_ok;
   logic       pop_ok;

   assign push_ok = ({1'b0, sp_q} >= PUSH_MIN);
   assign pop_ok  = (({1'b0, sp_q} + STEP_EXT) <= POP_MAX);

   // Next-state and per-cycle strobes; everything is forced low while in reset.
   always_comb begin
      state_next  = state;
      remain_next = remain;
      idx_next    = idx;
      req_ready   = 1'b0;
      sp_wr_ready = 1'b0;
      sp_d        = '0;
      sp_en       = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      word_idx    = 4'd0;
      done        = 1'b0;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;
      if (!rstn) begin
         state_next  = IDLE;
         remain_next = 4'd0;
         idx_next    = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               sp_wr_ready = 1'b1;
               req_ready   = !sp_wr_valid;
               if (sp_wr_valid) begin
                  sp_d  = sp_wr_data;
                  sp_en = 1'b1;
               end else if (req_valid) begin
                  remain_next = req_count;
                  idx_next    = 4'd0;
                  if (req_count == 4'd0) begin
                     state_next = FIN;
                  end else if (req_op) begin
                     state_next = POP;
                  end else begin
                     state_next = PUSH;
                  end
               end else begin
                  state_next = IDLE;
               end
            end
            PUSH: begin
               if (push_ok) begin
                  mem_addr    = sp_q - STEP;
                  mem_we      = 1'b1;
                  sp_d        = sp_q - STEP;
                  sp_en       = 1'b1;
                  word_idx    = idx;
                  remain_next = remain - 4'd1;
                  idx_next    = idx + 4'd1;
                  state_next  = (remain == 4'd1) ? FIN : PUSH;
               end else begin
                  ovf_set     = 1'b1;
                  remain_next = 4'd0;
                  state_next  = FIN;
               end
            end
            POP: begin
               if (pop_ok) begin
                  mem_addr    = sp_q;
                  mem_re      = 1'b1;
                  sp_d        = sp_q + STEP;
                  sp_en       = 1'b1;
                  word_idx    = idx;
                  remain_next = remain - 4'd1;
                  idx_next    = idx + 4'd1;
                  state_next  = (remain == 4'd1) ? FIN : POP;
               end else begin
                  unf_set     = 1'b1;
                  remain_next = 4'd0;
                  state_next  = FIN;
               end
            end
            FIN: begin
               done        = 1'b1;
               remain_next = 4'd0;
               state_next  = IDLE;
            end
            default: begin
               state_next  = IDLE;
               remain_next = 4'd0;
               idx_next    = 4'd0;
            end
         endcase
      end
   end

   // State, counters and sticky error flags; a set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         remain   <= 4'd0;
         idx      <= 4'd0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         state    <= state_next;
         remain   <= remain_next;
         idx      <= idx_next;
         ovf_flag <= ovf_set | (ovf_flag & ~err_clr);
         unf_flag <= unf_set | (unf_flag & ~err_clr);
      end
   end

   assign err_ovf = rstn & ovf_flag;
   assign err_unf = rstn & unf_flag;

endmodule
